// File: rtl/reg_stream_packer.sv
// reg_stream_packer: gathers RATIO consecutive WIDTH-bit samples into one
// wide word behind a single output register. A flush request emits a
// partially filled word together with its lane count. Lane 0 (the LSBs)
// holds the oldest sample. o_ready is the only path that is combinational
// from the downstream side; the data path is fully registered.
module reg_stream_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH-1:0]       i_d,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_flush,
    output logic [WIDTH*RATIO-1:0] o_data,
    output logic [CW-1:0]          o_count,
    output logic                   o_valid,
    input  logic                   i_ready
);

    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(RATIO);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    logic [WIDTH*RATIO-1:0] acc_data_q, acc_data_d;
    logic [CW-1:0]          acc_cnt_q, acc_cnt_d;
    logic [WIDTH*RATIO-1:0] out_data_q, out_data_d;
    logic [CW-1:0]          out_cnt_q, out_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   flush_pend_q, flush_pend_d;

    logic                   out_free_s;
    logic                   flush_req_s;
    logic                   ready_s;
    logic                   acc_s;
    logic                   load_s;
    logic [CW-1:0]          n_s;
    logic [WIDTH*RATIO-1:0] word_s;

    // Handshake decode: who may move this cycle and whether a word loads.
    always_comb begin
        out_free_s  = !out_valid_q || i_ready;
        flush_req_s = i_flush || flush_pend_q;
        // The last free lane is only offered when the word can leave at
        // once; a pending or requested flush freezes input while blocked.
        ready_s     = i_rst_n && (out_free_s ||
                      ((acc_cnt_q < LAST_LANE) && !i_flush && !flush_pend_q));
        acc_s       = i_valid && ready_s;
        n_s         = acc_cnt_q + {{(CW-1){1'b0}}, acc_s};
        // A full word can only form while the output is free (see ready_s).
        load_s      = (n_s == FULL_CNT) ||
                      (flush_req_s && out_free_s && (n_s != CNT_ZERO));
    end

    // Accumulator image including the sample accepted this cycle.
    always_comb begin
        word_s = acc_data_q;
        for (int k = 0; k < RATIO; k++) begin
            if (acc_s && (acc_cnt_q == CW'(k))) begin
                word_s[k*WIDTH +: WIDTH] = i_d;
            end else begin
                word_s[k*WIDTH +: WIDTH] = acc_data_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for accumulator, output register and deferred flush.
    always_comb begin
        acc_data_d   = word_s;
        acc_cnt_d    = n_s;
        out_data_d   = out_data_q;
        out_cnt_d    = out_cnt_q;
        out_valid_d  = out_valid_q && !i_ready;
        flush_pend_d = flush_pend_q;
        if (load_s) begin
            out_data_d  = word_s;
            out_cnt_d   = n_s;
            out_valid_d = 1'b1;
            acc_data_d  = {(WIDTH*RATIO){1'b0}};
            acc_cnt_d   = CNT_ZERO;
        end else begin
            out_valid_d = out_valid_q && !i_ready;
        end
        if (flush_req_s) begin
            // Blocked flushes are remembered; a free output executes them.
            flush_pend_d = !out_free_s;
        end else begin
            flush_pend_d = flush_pend_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc_data_q   <= {(WIDTH*RATIO){1'b0}};
            acc_cnt_q    <= CNT_ZERO;
            out_data_q   <= {(WIDTH*RATIO){1'b0}};
            out_cnt_q    <= CNT_ZERO;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_data_q   <= acc_data_d;
            acc_cnt_q    <= acc_cnt_d;
            out_data_q   <= out_data_d;
            out_cnt_q    <= out_cnt_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign o_ready = ready_s;
    assign o_data  = out_data_q;
    assign o_count = out_cnt_q;
    assign o_valid = out_valid_q;

endmodule
